// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI read crossbar in front of the CLINT.
package axi_pkg;

    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam logic [1:0]  RESP_DECERR    = 2'b11;
    localparam logic [31:0] DEF_CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] DEF_CLINT_MASK = 32'hFFFF_0000;
    localparam int          DEF_ID_W       = 4;

    typedef enum logic [1:0] {
        TGT_CLINT,
        TGT_SOC,
        TGT_ERR
    } xbar_tgt_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_ERR
    } xbar_state_e;

endpackage

// File: rtl/axi_rd_xbar_if.sv
// AXI4 read-only channel bundle; ADDR_W is 1 on the CLINT side (word select only).
interface axi_rd_xbar_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid;
    logic              rready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [ID_W-1:0]   rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/axi_rd_decode.sv
// Combinational target decode: CLINT only serves single-beat reads of the two mtime words.
module axi_rd_decode
    import axi_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
    parameter logic [31:0] CLINT_MASK = DEF_CLINT_MASK
) (
    input  logic [31:0] i_addr,
    input  logic [7:0]  i_len,
    output xbar_tgt_e   o_tgt
);

    logic w_in_win;
    logic w_clint_ok;

    assign w_in_win   = (i_addr & CLINT_MASK) == CLINT_BASE;
    assign w_clint_ok = (i_addr[15:3] == 13'd0) && (i_len == 8'd0);

    always_comb begin
        o_tgt = TGT_SOC;
        if (w_in_win) begin
            o_tgt = w_clint_ok ? TGT_CLINT : TGT_ERR;
        end
    end

endmodule

// File: rtl/axi_rd_xbar.sv
// One-outstanding AXI4 read crossbar: LSU master -> CLINT / SoC bus, local DECERR bursts.
module axi_rd_xbar
    import axi_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
    parameter logic [31:0] CLINT_MASK = DEF_CLINT_MASK,
    parameter int          ID_W       = DEF_ID_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    axi_rd_xbar_if.slave  m_if,
    axi_rd_xbar_if.master c_if,
    axi_rd_xbar_if.master s_if
);

    xbar_state_e     r_state;
    xbar_state_e     w_state_nxt;
    xbar_tgt_e       r_tgt;
    xbar_tgt_e       w_tgt;
    logic [31:0]     r_addr;
    logic [ID_W-1:0] r_id;
    logic [7:0]      r_len;
    logic [2:0]      r_size;
    logic [1:0]      r_burst;
    logic [7:0]      r_cnt;
    logic [7:0]      w_cnt_nxt;
    logic            w_ar_hs;
    logic            w_unused_rid;

    axi_rd_decode #(
        .CLINT_BASE(CLINT_BASE),
        .CLINT_MASK(CLINT_MASK)
    ) u_decode (
        .i_addr(m_if.araddr),
        .i_len (m_if.arlen),
        .o_tgt (w_tgt)
    );

    assign w_ar_hs = (r_state == ST_IDLE) && !i_rst && m_if.arvalid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Payload is frozen from acceptance until the last beat; CLINT rdata depends on r_addr[2].
    always_ff @(posedge i_clk) begin
        if (w_ar_hs) begin
            r_tgt   <= w_tgt;
            r_addr  <= m_if.araddr;
            r_id    <= m_if.arid;
            r_len   <= m_if.arlen;
            r_size  <= m_if.arsize;
            r_burst <= m_if.arburst;
        end
    end

    assign c_if.araddr  = r_addr[2];
    assign c_if.arid    = r_id;
    assign c_if.arlen   = r_len;
    assign c_if.arsize  = r_size;
    assign c_if.arburst = r_burst;
    assign s_if.araddr  = r_addr;
    assign s_if.arid    = r_id;
    assign s_if.arlen   = r_len;
    assign s_if.arsize  = r_size;
    assign s_if.arburst = r_burst;

    // Slave IDs are not forwarded; the master always sees the captured ID.
    assign w_unused_rid = ^{c_if.rid, s_if.rid};

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        m_if.arready = 1'b0;
        m_if.rvalid  = 1'b0;
        m_if.rdata   = 32'd0;
        m_if.rresp   = RESP_OKAY;
        m_if.rlast   = 1'b0;
        m_if.rid     = r_id;
        c_if.arvalid = 1'b0;
        s_if.arvalid = 1'b0;
        c_if.rready  = 1'b0;
        s_if.rready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                m_if.arready = !i_rst;
                if (w_ar_hs) begin
                    w_cnt_nxt   = m_if.arlen;
                    w_state_nxt = (w_tgt == TGT_ERR) ? ST_ERR : ST_AR;
                end
            end
            ST_AR: begin
                if (r_tgt == TGT_CLINT) begin
                    c_if.arvalid = 1'b1;
                    if (c_if.arready) w_state_nxt = ST_R;
                end else begin
                    s_if.arvalid = 1'b1;
                    if (s_if.arready) w_state_nxt = ST_R;
                end
            end
            ST_R: begin
                if (r_tgt == TGT_CLINT) begin
                    m_if.rvalid = c_if.rvalid;
                    m_if.rdata  = c_if.rdata;
                    m_if.rresp  = c_if.rresp;
                    m_if.rlast  = c_if.rlast;
                    c_if.rready = m_if.rready;
                    if (c_if.rvalid && m_if.rready && c_if.rlast) w_state_nxt = ST_IDLE;
                end else begin
                    m_if.rvalid = s_if.rvalid;
                    m_if.rdata  = s_if.rdata;
                    m_if.rresp  = s_if.rresp;
                    m_if.rlast  = s_if.rlast;
                    s_if.rready = m_if.rready;
                    if (s_if.rvalid && m_if.rready && s_if.rlast) w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                // Counter runs arlen..0, so arlen=255 yields 256 beats without wrapping.
                m_if.rvalid = 1'b1;
                m_if.rresp  = RESP_DECERR;
                m_if.rlast  = (r_cnt == 8'd0);
                if (m_if.rready) begin
                    if (r_cnt == 8'd0) w_state_nxt = ST_IDLE;
                    else               w_cnt_nxt   = r_cnt - 8'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_xbar.sv
// Self-checking bench: decode table, SoC bursts with gaps, hold-off, mid-burst reset, 256-beat DECERR.
module tb_axi_rd_xbar;
    import axi_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        xbar_tgt_e   tgt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_rd_xbar_if #(.ADDR_W(32), .ID_W(4)) m_if ();
    axi_rd_xbar_if #(.ADDR_W(1),  .ID_W(4)) c_if ();
    axi_rd_xbar_if #(.ADDR_W(32), .ID_W(4)) s_if ();

    axi_rd_xbar #(
        .CLINT_BASE(32'h0200_0000),
        .CLINT_MASK(32'hFFFF_0000),
        .ID_W      (4)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .m_if (m_if),
        .c_if (c_if),
        .s_if (s_if)
    );

    logic [63:0] mtime = 64'h1_0000_0010;

    // CLINT stand-in: always ready, rvalid tied high, rdata selected by word address.
    assign c_if.arready = 1'b1;
    assign c_if.rvalid  = 1'b1;
    assign c_if.rdata   = c_if.araddr[0] ? mtime[63:32] : mtime[31:0];
    assign c_if.rresp   = RESP_OKAY;
    assign c_if.rlast   = 1'b1;
    assign c_if.rid     = 4'hF;

    beat_t sb_q[$];
    beat_t soc_q[$];
    beat_t mon_e;
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    last_rlast_cyc = -10;
    int    acc_cyc = 0;
    int    s_ar_pulses = 0;
    int    n_beats = 0;
    int    rdy_mode = 0;
    bit    soc_gaps = 1'b0;
    bit    soc_flush = 1'b0;
    logic  s_ar_hs, s_r_hs, s_prev_arv = 1'b0;
    logic [31:0] s_ar_addr;
    logic [3:0]  s_ar_id;
    logic [7:0]  s_ar_len;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] soc_data(input logic [31:0] a, input int i);
        return (a + 32'(i * 4)) ^ 32'h5A00_0000;
    endfunction

    // SoC slave model, master-side rready driver and R-channel monitor.
    always begin
        @(negedge clk);
        s_ar_hs   = s_if.arvalid && s_if.arready;
        s_ar_addr = s_if.araddr;
        s_ar_id   = s_if.arid;
        s_ar_len  = s_if.arlen;
        s_r_hs    = s_if.rvalid && s_if.rready;
        if (s_if.arvalid && !s_prev_arv) s_ar_pulses++;
        s_prev_arv = s_if.arvalid;
        if (m_if.rvalid && m_if.rready) begin
            n_beats++;
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: actual data %h, required no beat", m_if.rdata);
            end else begin
                mon_e = sb_q.pop_front();
                chk("r_beat", {m_if.rdata, m_if.rresp, m_if.rlast, m_if.rid}, mon_e);
            end
            if (m_if.rlast) last_rlast_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (soc_flush) begin
            soc_q.delete();
            s_if.rvalid = 1'b0;
            soc_flush = 1'b0;
        end else begin
            if (s_r_hs && soc_q.size() > 0) void'(soc_q.pop_front());
            if (s_ar_hs) begin
                for (int i = 0; i <= int'(s_ar_len); i++)
                    soc_q.push_back('{soc_data(s_ar_addr, i), RESP_OKAY, (i == int'(s_ar_len)), ~s_ar_id});
            end
            if (!(s_if.rvalid && !s_r_hs))
                s_if.rvalid = (soc_q.size() > 0) && (!soc_gaps || $urandom_range(0, 1) == 1);
            if (soc_q.size() > 0)
                {s_if.rdata, s_if.rresp, s_if.rlast, s_if.rid} = soc_q[0];
        end
        case (rdy_mode)
            0:       m_if.rready = 1'b1;
            1:       m_if.rready = ($urandom_range(0, 1) == 1);
            default: m_if.rready = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input xbar_tgt_e tgt, input string nm);
        int  w;
        bit  got;
        for (int i = 0; i <= int'(len); i++) begin
            case (tgt)
                TGT_CLINT: sb_q.push_back('{a[2] ? mtime[63:32] : mtime[31:0], RESP_OKAY, 1'b1, id});
                TGT_SOC:   sb_q.push_back('{soc_data(a, i), RESP_OKAY, (i == int'(len)), id});
                default:   sb_q.push_back('{32'd0, 2'b11, (i == int'(len)), id});
            endcase
        end
        m_if.araddr  = a;
        m_if.arid    = id;
        m_if.arlen   = len;
        m_if.arsize  = 3'd2;
        m_if.arburst = 2'b01;
        m_if.arvalid = 1'b1;
        w   = 0;
        got = 1'b0;
        while (!got && w < 600) begin
            @(negedge clk);
            if (m_if.arready) got = 1'b1;
            else w++;
        end
        if (!got) begin
            chk({nm, "_ar_timeout"}, 64'd0, 64'd1);
            m_if.arvalid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        tick();
        m_if.arvalid = 1'b0;
        @(negedge clk);
        chk({nm, "_c_arvalid"}, 64'(c_if.arvalid), 64'(tgt == TGT_CLINT));
        chk({nm, "_s_arvalid"}, 64'(s_if.arvalid), 64'(tgt == TGT_SOC));
        chk({nm, "_m_rvalid"},  64'(m_if.rvalid),  64'(tgt == TGT_ERR));
        chk({nm, "_m_arready"}, 64'(m_if.arready), 64'd0);
        if (tgt == TGT_CLINT) chk({nm, "_c_araddr"}, 64'(c_if.araddr), 64'(a[2]));
    endtask

    task automatic wait_drain(input string nm);
        int w = 0;
        while (sb_q.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk({nm, "_drain_left"}, 64'(sb_q.size()), 64'd0);
        tick();
    endtask

    vec_t vecs [9];
    int   nb0;

    initial begin
        vecs[0] = '{32'h0200_0004, 4'h1, 8'd0, TGT_CLINT};
        vecs[1] = '{32'h0200_0000, 4'h2, 8'd0, TGT_CLINT};
        vecs[2] = '{32'h8000_0000, 4'h3, 8'd3, TGT_SOC};
        vecs[3] = '{32'h0200_0010, 4'h4, 8'd0, TGT_ERR};
        vecs[4] = '{32'h0200_0000, 4'h5, 8'd2, TGT_ERR};
        vecs[5] = '{32'h0200_8000, 4'h6, 8'd0, TGT_ERR};
        vecs[6] = '{32'h0201_0000, 4'h7, 8'd1, TGT_SOC};
        vecs[7] = '{32'h0200_0004, 4'h8, 8'd1, TGT_ERR};
        vecs[8] = '{32'h01FF_FFFC, 4'h9, 8'd0, TGT_SOC};

        m_if.arvalid = 1'b0;
        m_if.araddr  = 32'd0;
        m_if.arid    = 4'd0;
        m_if.arlen   = 8'd0;
        m_if.arsize  = 3'd0;
        m_if.arburst = 2'd0;
        m_if.rready  = 1'b1;
        s_if.arready = 1'b1;
        s_if.rvalid  = 1'b0;
        s_if.rdata   = 32'd0;
        s_if.rresp   = 2'd0;
        s_if.rlast   = 1'b0;
        s_if.rid     = 4'd0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_m_arready", 64'(m_if.arready), 64'd0);
        chk("rst_c_arvalid", 64'(c_if.arvalid), 64'd0);
        chk("rst_s_arvalid", 64'(s_if.arvalid), 64'd0);
        chk("rst_m_rvalid",  64'(m_if.rvalid),  64'd0);
        chk("rst_m_rlast",   64'(m_if.rlast),   64'd0);
        chk("rst_rready",    64'({c_if.rready, s_if.rready}), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_m_arready", 64'(m_if.arready), 64'd1);
        tick();

        foreach (vecs[k]) begin
            do_ar(vecs[k].addr, vecs[k].id, vecs[k].len, vecs[k].tgt, $sformatf("vec%0d", k));
            wait_drain($sformatf("vec%0d", k));
        end

        // SoC burst with slave and master gaps; exactly one AR pulse
        soc_gaps = 1'b1;
        rdy_mode = 1;
        tick();
        s_ar_pulses = 0;
        do_ar(32'h8000_0000, 4'hC, 8'd3, TGT_SOC, "soc_gap");
        wait_drain("soc_gap");
        chk("soc_gap_ar_pulses", 64'(s_ar_pulses), 64'd1);

        // Second request held off until the cycle after the final beat
        do_ar(32'h8000_0040, 4'h5, 8'd3, TGT_SOC, "hold_a");
        do_ar(32'h0200_0004, 4'h6, 8'd0, TGT_CLINT, "hold_b");
        chk("hold_accept_cycle", 64'(acc_cyc), 64'(last_rlast_cyc + 1));
        wait_drain("hold");

        // Reset in the middle of a SoC burst
        soc_gaps = 1'b0;
        rdy_mode = 0;
        tick();
        nb0 = n_beats;
        do_ar(32'h8000_0100, 4'h9, 8'd7, TGT_SOC, "rst_mid");
        for (int w = 0; w < 100 && (n_beats - nb0) < 2; w++) @(negedge clk);
        chk("rst_mid_beats_before", 64'(n_beats - nb0 >= 2), 64'd1);
        rdy_mode = 2;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_c_arvalid", 64'(c_if.arvalid), 64'd0);
        chk("rst_mid_s_arvalid", 64'(s_if.arvalid), 64'd0);
        chk("rst_mid_m_rvalid",  64'(m_if.rvalid),  64'd0);
        chk("rst_mid_m_arready", 64'(m_if.arready), 64'd0);
        chk("rst_mid_s_rready",  64'(s_if.rready),  64'd0);
        sb_q.delete();
        soc_flush = 1'b1;
        tick();
        rst = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        chk("rst_mid_idle_arready", 64'(m_if.arready), 64'd1);
        tick();
        do_ar(32'h0200_0000, 4'h2, 8'd0, TGT_CLINT, "post_rst");
        wait_drain("post_rst");

        // 256-beat DECERR burst
        nb0 = n_beats;
        do_ar(32'h0200_0000, 4'hA, 8'd255, TGT_ERR, "err256");
        wait_drain("err256");
        chk("err256_beats", 64'(n_beats - nb0), 64'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual still running, required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_rd_xbar.md
# axi_rd_xbar

Single-master, two-slave AXI4 read crossbar that sits directly upstream of the CLINT. It accepts read requests from the core's LSU read port and routes each one to either the CLINT (mtime window) or the SoC AXI bus. Addresses that cannot be served return DECERR locally. It allows one outstanding transaction and forwards R beats, including bursts, back to the master.

## Interface
- CLINT_BASE, 32'h0200_0000, base of the CLINT window
- CLINT_MASK, 32'hFFFF_0000, window match mask (64 KiB window)
- ID_W, 4, AXI ID width
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- m_arvalid/m_arready  in/out  1/1  master AR handshake
- m_araddr/m_arid/m_arlen/m_arsize/m_arburst  in  32/ID_W/8/3/2  master AR payload
- m_rvalid/m_rready  out/in  1/1  master R handshake
- m_rdata/m_rresp/m_rlast/m_rid  out  32/2/1/ID_W  master R payload
- c_arvalid/c_arready  out/in  1/1  CLINT AR handshake
- c_araddr  out  1  CLINT word select = captured addr[2]
- c_arid/c_arlen/c_arsize/c_arburst  out  ID_W/8/3/2  CLINT AR payload
- c_rvalid/c_rready, c_rdata/c_rresp/c_rlast/c_rid  in/out, in  1/1, 32/2/1/ID_W  CLINT R channel
- s_ar* (valid out, ready in, addr 32, id, len, size, burst out)  SoC AR channel
- s_r* (valid in, ready out, data 32, resp, last, id in)  SoC R channel

## Operation
- Decode on captured address A:
  - CLINT if (A & CLINT_MASK) == CLINT_BASE, A[15:3] == 0 and arlen == 0.
  - DECERR if A is inside the window but the other two conditions fail.
  - SOC otherwise.
- FSM states: IDLE, AR, R, ERR.
  - IDLE: m_arready=1. On m_arvalid, register the full AR payload and the target, then go to AR (CLINT/SOC) or ERR.
  - AR: assert arvalid only on the selected slave, with the registered payload held stable. On that slave's arready, go to R.
  - R: combinational pass-through between the selected slave's R channel and the master. The unselected slave's rready is 0. On a beat with rvalid&rready&rlast, go to IDLE.
  - ERR: drive m_rvalid=1, m_rresp=2'b11, m_rdata=0, m_rid=captured ID. An 8-bit beat counter counts from captured arlen down to 0. m_rlast=1 when the counter is 0. Each m_rready decrements the counter. The last beat returns to IDLE.
- c_rvalid is ignored outside R/CLINT. The CLINT drives rvalid constantly high.
- c_araddr stays stable from AR through the end of R because CLINT rdata is a combinational function of it.
- m_rid is always the captured ID. Slave rid is not forwarded.

## Timing
- Reset values: m_arready=0 while reset is high, and 1 from the first IDLE cycle after reset. c_arvalid=s_arvalid=0, m_rvalid=0, m_rlast=0, c_rready=s_rready=0. State=IDLE, counter=0.
- Reset is sampled every cycle. Reset mid-transaction forces IDLE on the next edge and drops all valids. No beat is completed afterwards.
- If the AR handshake happens at edge N, the slave arvalid is high in cycle N+1. With arready=1, R is entered at edge N+1.
- R beats add zero cycles of latency: m_rvalid = slave rvalid in the same cycle.
- An ERR first beat is presented in cycle N+1.
- Minimum CLINT round trip: AR accepted at N, data beat in cycle N+2, IDLE again at N+3.
- m_arready=0 in AR, R and ERR. No new request is accepted until the final beat completes.
- Master stall (m_rready=0) holds the state. Slave payload is passed through unchanged.
- arlen=255 ERR burst gives 256 beats; the counter must not wrap early.

## Structure
- Shared package axi_pkg holds:
  - the RESP_OKAY/RESP_DECERR constants
  - the xbar_tgt_e enum (TGT_CLINT, TGT_SOC, TGT_ERR)
  - the FSM state enum
  - the CLINT_BASE/CLINT_MASK defaults
- One natural sub-module, axi_rd_decode: a purely combinational address/length decoder that returns xbar_tgt_e.
- Everything else lives in axi_rd_xbar.

## Test plan
- Read at 0x0200_0004, arlen=0, with CLINT mtime=0x1_0000_0010 -> c_araddr=1, and the master receives rdata=0x0000_0001, resp=OKAY, rlast=1, rid=the request ID.
- Read at 0x8000_0000, arlen=3, with the SoC returning 4 beats and random rvalid/m_rready gaps -> 4 beats delivered in order, the last carries rlast, and s_arvalid pulses exactly once.
- Read at 0x0200_0010 -> no slave arvalid; 1 beat with resp=2'b11, rdata=0, rlast=1. Read at 0x0200_0000 with arlen=2 -> 3 DECERR beats, rlast on the third only.
- A second m_arvalid held during an outstanding SoC burst -> m_arready stays 0 until the cycle after the final rlast beat, then the second request is accepted.
- reset asserted in R mid-burst -> all valids 0 next cycle and state IDLE; a following CLINT read completes normally.
- arlen=255 to a DECERR address with m_rready=1 -> exactly 256 beats, rlast only on beat 256.
